// File: rtl/z480_pkg.sv
// Shared Z480 privilege-framework types and constants.
// Imported by the trap sequencer, its interface and the bench.
package z480_pkg;

    typedef enum logic [1:0] {
        Z480_PRIV_U = 2'b00,
        Z480_PRIV_S = 2'b01,
        Z480_PRIV_H = 2'b11
    } z480_priv_e;

    typedef enum logic [2:0] {
        TS_IDLE,
        TS_FLUSH,
        TS_ENTER,
        TS_RFLUSH,
        TS_RETURN
    } z480_trap_state_e;

    localparam int         Z480_CAUSE_W       = 7;
    localparam logic [5:0] Z480_CAUSE_ILL_RET = 6'h02;
    localparam logic [5:0] Z480_CAUSE_DFAULT  = 6'h3F;

    function automatic logic [63:0] z480_vec_addr(
        input logic [63:0]             base,
        input logic [Z480_CAUSE_W-1:0] c,
        input int                      sh
    );
        return base + ({57'b0, c} << sh);
    endfunction

endpackage

// File: rtl/trap_entry_seq_if.sv
// Trap sequencer bundle: privilege state, pipeline events,
// flush handshake and trap/return results.
interface trap_entry_seq_if #(
    parameter int IRQ_N = 32
);
    import z480_pkg::*;

    logic [IRQ_N-1:0]        ie;
    logic [IRQ_N-1:0]        ip;
    z480_priv_e              priv_mode;
    logic [63:0]             tv_s_base;
    logic [63:0]             tv_h_base;
    logic                    irq_take_ok;
    logic [63:0]             cur_pc;
    logic                    exc_valid;
    logic [5:0]              exc_cause;
    logic [63:0]             exc_pc;
    logic                    trap_ret_valid;
    logic                    flush_req;
    logic                    flush_ack;
    logic                    redirect_valid;
    logic [63:0]             redirect_pc;
    logic                    set_priv_valid;
    z480_priv_e              set_priv_mode;
    logic [63:0]             epc;
    logic [Z480_CAUSE_W-1:0] cause;
    z480_priv_e              prev_priv;
    logic                    in_trap;
    logic                    double_fault;
    logic                    busy;

    modport master (
        output ie, ip, priv_mode, tv_s_base, tv_h_base,
        output irq_take_ok, cur_pc, exc_valid, exc_cause,
        output exc_pc, trap_ret_valid, flush_ack,
        input  flush_req, redirect_valid, redirect_pc,
        input  set_priv_valid, set_priv_mode, epc, cause,
        input  prev_priv, in_trap, double_fault, busy
    );

    modport slave (
        input  ie, ip, priv_mode, tv_s_base, tv_h_base,
        input  irq_take_ok, cur_pc, exc_valid, exc_cause,
        input  exc_pc, trap_ret_valid, flush_ack,
        output flush_req, redirect_valid, redirect_pc,
        output set_priv_valid, set_priv_mode, epc, cause,
        output prev_priv, in_trap, double_fault, busy
    );

endinterface

// File: rtl/irq_prio_enc.sv
// Lowest-index-wins priority encoder over up to 64 request lines.
module irq_prio_enc #(
    parameter int IRQ_N = 32
) (
    input  logic [IRQ_N-1:0] req,
    output logic             valid,
    output logic [5:0]       idx
);

    always_comb begin
        valid = |req;
        idx   = '0;
        // Walk downwards so the lowest set bit is the final assignment.
        for (int i = IRQ_N - 1; i >= 0; i--) begin
            if (req[i]) idx = 6'(i);
        end
    end

endmodule

// File: rtl/trap_entry_seq.sv
// Trap entry / xRET sequencer: arbitrates events in IDLE, runs the
// flush handshake, then redirects the PC and updates privilege state.
module trap_entry_seq
    import z480_pkg::*;
#(
    parameter int IRQ_N           = 32,
    parameter int VEC_STRIDE_LOG2 = 4
) (
    input logic             clk,
    input logic             rst,
    trap_entry_seq_if.slave bus
);

    logic [IRQ_N-1:0] irq_req;
    logic             irq_vld;
    logic [5:0]       irq_idx;

    assign irq_req = bus.ie & bus.ip;

    irq_prio_enc #(.IRQ_N(IRQ_N)) u_enc (
        .req   (irq_req),
        .valid (irq_vld),
        .idx   (irq_idx)
    );

    z480_trap_state_e        state_q, state_d;
    logic                    flush_req_q, flush_req_d;
    logic                    redir_vld_q, redir_vld_d;
    logic [63:0]             redir_pc_q, redir_pc_d;
    logic                    spriv_vld_q, spriv_vld_d;
    z480_priv_e              spriv_mode_q, spriv_mode_d;
    logic [63:0]             epc_q, epc_d;
    logic [Z480_CAUSE_W-1:0] cause_q, cause_d;
    z480_priv_e              prev_priv_q, prev_priv_d;
    logic                    in_trap_q, in_trap_d;
    logic                    dfault_q, dfault_d;
    logic                    busy_q, busy_d;
    logic [Z480_CAUSE_W-1:0] pend_cause_q, pend_cause_d;
    logic [63:0]             pend_vec_q, pend_vec_d;
    logic [63:0]             pend_epc_q, pend_epc_d;
    z480_priv_e              pend_mode_q, pend_mode_d;
    z480_priv_e              pend_prev_q, pend_prev_d;

    logic                    ev_take;
    logic                    ev_ret;
    logic                    ev_dfault;
    logic [Z480_CAUSE_W-1:0] ev_cause;
    z480_priv_e              ev_tgt;
    logic [63:0]             ev_epc;
    logic [63:0]             ev_base;

    always_comb begin
        ev_take   = 1'b0;
        ev_ret    = 1'b0;
        ev_dfault = 1'b0;
        ev_cause  = '0;
        ev_epc    = bus.cur_pc;
        ev_tgt    = (bus.priv_mode == Z480_PRIV_H) ? Z480_PRIV_H
                                                   : Z480_PRIV_S;
        if (bus.exc_valid) begin
            ev_take = 1'b1;
            ev_epc  = bus.exc_pc;
            if (in_trap_q) begin
                ev_dfault = 1'b1;
                ev_tgt    = Z480_PRIV_H;
                ev_cause  = {1'b0, Z480_CAUSE_DFAULT};
            end else begin
                ev_cause  = {1'b0, bus.exc_cause};
            end
        end else if (bus.trap_ret_valid && in_trap_q) begin
            ev_ret = 1'b1;
        end else if (bus.trap_ret_valid) begin
            ev_take  = 1'b1;
            ev_cause = {1'b0, Z480_CAUSE_ILL_RET};
        end else if (bus.irq_take_ok && !in_trap_q && irq_vld) begin
            ev_take  = 1'b1;
            ev_cause = {1'b1, irq_idx};
        end
        ev_base = (ev_tgt == Z480_PRIV_H) ? bus.tv_h_base : bus.tv_s_base;
    end

    always_comb begin
        state_d      = state_q;
        flush_req_d  = flush_req_q;
        redir_vld_d  = 1'b0;
        redir_pc_d   = redir_pc_q;
        spriv_vld_d  = 1'b0;
        spriv_mode_d = spriv_mode_q;
        epc_d        = epc_q;
        cause_d      = cause_q;
        prev_priv_d  = prev_priv_q;
        in_trap_d    = in_trap_q;
        dfault_d     = dfault_q;
        pend_cause_d = pend_cause_q;
        pend_vec_d   = pend_vec_q;
        pend_epc_d   = pend_epc_q;
        pend_mode_d  = pend_mode_q;
        pend_prev_d  = pend_prev_q;
        unique case (state_q)
            TS_IDLE: begin
                if (ev_take) begin
                    state_d      = TS_FLUSH;
                    flush_req_d  = 1'b1;
                    dfault_d     = dfault_q | ev_dfault;
                    pend_cause_d = ev_cause;
                    pend_mode_d  = ev_tgt;
                    pend_epc_d   = ev_epc;
                    pend_prev_d  = bus.priv_mode;
                    pend_vec_d   = z480_vec_addr(ev_base, ev_cause,
                                                 VEC_STRIDE_LOG2);
                end else if (ev_ret) begin
                    state_d     = TS_RFLUSH;
                    flush_req_d = 1'b1;
                end
            end
            TS_FLUSH: begin
                if (bus.flush_ack) begin
                    state_d      = TS_ENTER;
                    flush_req_d  = 1'b0;
                    redir_vld_d  = 1'b1;
                    redir_pc_d   = pend_vec_q;
                    spriv_vld_d  = 1'b1;
                    spriv_mode_d = pend_mode_q;
                    epc_d        = pend_epc_q;
                    cause_d      = pend_cause_q;
                    prev_priv_d  = pend_prev_q;
                    in_trap_d    = 1'b1;
                end
            end
            TS_RFLUSH: begin
                if (bus.flush_ack) begin
                    state_d      = TS_RETURN;
                    flush_req_d  = 1'b0;
                    redir_vld_d  = 1'b1;
                    redir_pc_d   = epc_q;
                    spriv_vld_d  = 1'b1;
                    spriv_mode_d = prev_priv_q;
                    in_trap_d    = 1'b0;
                end
            end
            TS_ENTER:  state_d = TS_IDLE;
            TS_RETURN: state_d = TS_IDLE;
            default:   state_d = TS_IDLE;
        endcase
        busy_d = (state_d != TS_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= TS_IDLE;
            flush_req_q  <= 1'b0;
            redir_vld_q  <= 1'b0;
            redir_pc_q   <= '0;
            spriv_vld_q  <= 1'b0;
            spriv_mode_q <= Z480_PRIV_S;
            epc_q        <= '0;
            cause_q      <= '0;
            prev_priv_q  <= Z480_PRIV_S;
            in_trap_q    <= 1'b0;
            dfault_q     <= 1'b0;
            busy_q       <= 1'b0;
            pend_cause_q <= '0;
            pend_vec_q   <= '0;
            pend_epc_q   <= '0;
            pend_mode_q  <= Z480_PRIV_S;
            pend_prev_q  <= Z480_PRIV_S;
        end else begin
            state_q      <= state_d;
            flush_req_q  <= flush_req_d;
            redir_vld_q  <= redir_vld_d;
            redir_pc_q   <= redir_pc_d;
            spriv_vld_q  <= spriv_vld_d;
            spriv_mode_q <= spriv_mode_d;
            epc_q        <= epc_d;
            cause_q      <= cause_d;
            prev_priv_q  <= prev_priv_d;
            in_trap_q    <= in_trap_d;
            dfault_q     <= dfault_d;
            busy_q       <= busy_d;
            pend_cause_q <= pend_cause_d;
            pend_vec_q   <= pend_vec_d;
            pend_epc_q   <= pend_epc_d;
            pend_mode_q  <= pend_mode_d;
            pend_prev_q  <= pend_prev_d;
        end
    end

    assign bus.flush_req      = flush_req_q;
    assign bus.redirect_valid = redir_vld_q;
    assign bus.redirect_pc    = redir_pc_q;
    assign bus.set_priv_valid = spriv_vld_q;
    assign bus.set_priv_mode  = spriv_mode_q;
    assign bus.epc            = epc_q;
    assign bus.cause          = cause_q;
    assign bus.prev_priv      = prev_priv_q;
    assign bus.in_trap        = in_trap_q;
    assign bus.double_fault   = dfault_q;
    assign bus.busy           = busy_q;

endmodule
